// File: rtl/lcd_hex_driver.sv
// rtl/lcd_hex_driver.sv - HD44780 16x2 LCD driver showing selector code and 32-bit debug word in hex
//
// Purpose: runs the LCD power-up wait and the 4-byte init sequence (0x38, 0x0C, 0x01, 0x06).
//          It then refreshes the panel forever with 34-byte frames:
//            line 1 "SEL=xx"
//            line 2 "0xXXXXXXXX"
//          Each byte is one SU -> EN -> WAIT transaction.
// Ports:
//   SYS_clk    - system clock, rising edge
//   SYS_rst    - asynchronous active-low reset
//   disp_data  - 32-bit debug word, captured at the start of each frame
//   disp_sel   - 8-bit selector code, captured at the start of each frame
//   LCD_DATA   - LCD data bus
//   LCD_RS     - 0 = command, 1 = character
//   LCD_RW     - tied 0 (write only)
//   LCD_EN     - registered enable strobe
//   LCD_ON     - tied 1
//   init_done  - high once init completes, until reset
//   frame_done - one-cycle pulse when a full frame has been written
module lcd_hex_driver #(
   parameter int T_PWR = 750000,
   parameter int T_SU  = 2,
   parameter int T_EN  = 12,
   parameter int T_GAP = 2000,
   parameter int T_CLR = 82000
) (
   input  logic        SYS_clk,
   input  logic        SYS_rst,
   input  logic [31:0] disp_data,
   input  logic [7:0]  disp_sel,
   output logic [7:0]  LCD_DATA,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic        LCD_ON,
   output logic        init_done,
   output logic        frame_done
);

   localparam int M1   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
   localparam int M2   = (T_GAP > T_EN) ? T_GAP : T_EN;
   localparam int M3   = (M2 > T_SU) ? M2 : T_SU;
   localparam int CMAX = (M1 > M3) ? M1 : M3;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] L_PWR = CW'(T_PWR - 1);
   localparam logic [CW-1:0] L_SU  = CW'(T_SU - 1);
   localparam logic [CW-1:0] L_EN  = CW'(T_EN - 1);
   localparam logic [CW-1:0] L_GAP = CW'(T_GAP - 1);
   localparam logic [CW-1:0] L_CLR = CW'(T_CLR - 1);

   typedef enum logic [1:0] {S_PWRUP, S_SU, S_EN, S_WAIT} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, wait_lim;
   logic [5:0]    idx, idx_n;
   logic          frm, frm_n;
   logic          en_n, rs_n, done_n, fd_n, load;
   logic [7:0]    data_n;
   logic [7:0]    snap_sel;
   logic [31:0]   snap_data;

   assign LCD_RW = 1'b0;
   assign LCD_ON = 1'b1;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte for position i of the init sequence (frm=0) or of a frame (frm=1).
   function automatic logic [7:0] byte_for(input logic frm_i, input logic [5:0] i,
                                           input logic [7:0] s, input logic [31:0] d);
      logic [7:0] b;
      b = 8'h20;
      if (!frm_i) begin
         case (i[1:0])
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            default: b = 8'h06;
         endcase
      end else begin
         case (i)
            6'd0:    b = 8'h80;
            6'd1:    b = 8'h53;
            6'd2:    b = 8'h45;
            6'd3:    b = 8'h4C;
            6'd4:    b = 8'h3D;
            6'd5:    b = hex_ascii(s[7:4]);
            6'd6:    b = hex_ascii(s[3:0]);
            6'd17:   b = 8'hC0;
            6'd18:   b = 8'h30;
            6'd19:   b = 8'h78;
            6'd20:   b = hex_ascii(d[31:28]);
            6'd21:   b = hex_ascii(d[27:24]);
            6'd22:   b = hex_ascii(d[23:20]);
            6'd23:   b = hex_ascii(d[19:16]);
            6'd24:   b = hex_ascii(d[15:12]);
            6'd25:   b = hex_ascii(d[11:8]);
            6'd26:   b = hex_ascii(d[7:4]);
            6'd27:   b = hex_ascii(d[3:0]);
            default: b = 8'h20;
         endcase
      end
      return b;
   endfunction

   // Clear-display (init byte 2) needs the long post-pulse wait.
   assign wait_lim = (!frm && idx == 6'd2) ? L_CLR : L_GAP;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      frm_n   = frm;
      en_n    = LCD_EN;
      rs_n    = LCD_RS;
      data_n  = LCD_DATA;
      done_n  = init_done;
      fd_n    = 1'b0;
      load    = 1'b0;
      case (state)
         S_PWRUP: if (cnt == L_PWR) begin
            state_n = S_SU;
            cnt_n   = '0;
            idx_n   = '0;
            frm_n   = 1'b0;
            load    = 1'b1;
         end
         S_SU: if (cnt == L_SU) begin
            state_n = S_EN;
            cnt_n   = '0;
            en_n    = 1'b1;
         end
         S_EN: if (cnt == L_EN) begin
            state_n = S_WAIT;
            cnt_n   = '0;
            en_n    = 1'b0;
         end
         default: if (cnt == wait_lim) begin
            state_n = S_SU;
            cnt_n   = '0;
            load    = 1'b1;
            if (!frm && idx == 6'd3) begin
               frm_n  = 1'b1;
               idx_n  = '0;
               done_n = 1'b1;
            end else if (frm && idx == 6'd33) begin
               idx_n = '0;
               fd_n  = 1'b1;
            end else begin
               idx_n = idx + 6'd1;
            end
         end
      endcase
      // Data and RS are only updated when a new SU begins, so they hold through EN and WAIT.
      if (load) begin
         data_n = byte_for(frm_n, idx_n, snap_sel, snap_data);
         rs_n   = frm_n && (idx_n != 6'd0) && (idx_n != 6'd17);
      end
   end

   always_ff @(posedge SYS_clk or negedge SYS_rst) begin
      if (!SYS_rst) begin
         state      <= S_PWRUP;
         cnt        <= '0;
         idx        <= '0;
         frm        <= 1'b0;
         LCD_EN     <= 1'b0;
         LCD_RS     <= 1'b0;
         LCD_DATA   <= 8'h00;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
         snap_sel   <= 8'h00;
         snap_data  <= 32'h0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         frm        <= frm_n;
         LCD_EN     <= en_n;
         LCD_RS     <= rs_n;
         LCD_DATA   <= data_n;
         init_done  <= done_n;
         frame_done <= fd_n;
         // Capture on the first cycle of the 0x80 transaction; characters are loaded later.
         if (state == S_SU && frm && idx == 6'd0 && cnt == '0) begin
            snap_sel  <= disp_sel;
            snap_data <= disp_data;
         end
      end
   end

endmodule
